// File: rtl/pipe_pkg.sv
// Shared pipeline constants: ALU control codes, alu_op encodings, R-type funct values,
// and the ID/EX register layout with its forwarding helper.
package pipe_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    typedef struct packed {
        logic [31:0] read_data1;
        logic [31:0] read_data2;
        logic [31:0] imm_ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [1:0]  alu_op;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

    // Youngest producer wins; register 0 is hardwired and never forwarded.
    function automatic logic [31:0] fwd_operand(
        input logic [4:0]  src_reg,
        input logic [31:0] reg_data,
        input logic        exmem_we,
        input logic [4:0]  exmem_rd,
        input logic [31:0] exmem_data,
        input logic        memwb_we,
        input logic [4:0]  memwb_rd,
        input logic [31:0] memwb_data
    );
        logic [31:0] result;
        result = reg_data;
        if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == src_reg)) begin
            result = exmem_data;
        end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == src_reg)) begin
            result = memwb_data;
        end
        return result;
    endfunction

endpackage

// File: rtl/alu_control_decode.sv
// Maps registered alu_op/funct to a 4-bit ALU control code; purely combinational, no latency.
// No flow control: result follows its inputs within the same cycle.
module alu_control_decode
    import pipe_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_NONE;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_OR:  alu_control = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    FUNCT_NOR: alu_control = ALU_NOR;
                    default:   alu_control = ALU_NONE;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus EX operand forwarding and ALU control; 1-cycle capture latency.
// Backpressure: stall holds the register, flush loads a bubble and overrides stall.
module ex_operand_stage
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] id_read_data1,
    input  logic [31:0] id_read_data2,
    input  logic [31:0] id_imm_ext,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [5:0]  id_funct,
    input  logic [1:0]  id_alu_op,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_alu_out,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_write_data,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_write_reg,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt
);

    idex_t idex_q;
    idex_t idex_d;
    logic [31:0] forward_a;
    logic [31:0] forward_b;

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = IDEX_BUBBLE;
        end else if (!stall) begin
            idex_d.read_data1 = id_read_data1;
            idex_d.read_data2 = id_read_data2;
            idex_d.imm_ext    = id_imm_ext;
            idex_d.rs         = id_rs;
            idex_d.rt         = id_rt;
            idex_d.rd         = id_rd;
            idex_d.funct      = id_funct;
            idex_d.alu_op     = id_alu_op;
            idex_d.alu_src    = id_alu_src;
            idex_d.reg_dst    = id_reg_dst;
            idex_d.reg_write  = id_reg_write;
            idex_d.mem_read   = id_mem_read;
            idex_d.mem_write  = id_mem_write;
            idex_d.mem_to_reg = id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q <= IDEX_BUBBLE;
        end else begin
            idex_q <= idex_d;
        end
    end

    alu_control_decode u_alu_control_decode (
        .alu_op      (idex_q.alu_op),
        .funct       (idex_q.funct),
        .alu_control (alu_control)
    );

    // Forwarding uses the live EX/MEM and MEM/WB buses, not registered copies.
    always_comb begin
        forward_a = fwd_operand(idex_q.rs, idex_q.read_data1,
                                exmem_reg_write, exmem_rd, exmem_alu_out,
                                memwb_reg_write, memwb_rd, memwb_write_data);
        forward_b = fwd_operand(idex_q.rt, idex_q.read_data2,
                                exmem_reg_write, exmem_rd, exmem_alu_out,
                                memwb_reg_write, memwb_rd, memwb_write_data);
    end

    always_comb begin
        alu_a         = forward_a;
        alu_b         = idex_q.alu_src ? idex_q.imm_ext : forward_b;
        ex_store_data = forward_b;
        ex_write_reg  = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
        ex_reg_write  = idex_q.reg_write;
        ex_mem_read   = idex_q.mem_read;
        ex_mem_write  = idex_q.mem_write;
        ex_mem_to_reg = idex_q.mem_to_reg;
        ex_rs         = idex_q.rs;
        ex_rt         = idex_q.rt;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage with hand-computed expectations.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] id_read_data1, id_read_data2, id_imm_ext;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_alu_out;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_write_data;
    logic [3:0]  alu_control;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  ex_write_reg, ex_rs, ex_rt;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int n_checks = 0;
    int n_errs   = 0;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm_ext(id_imm_ext),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_write_data(memwb_write_data),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
        .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rs(ex_rs), .ex_rt(ex_rt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_read_data1 = '0; id_read_data2 = '0; id_imm_ext = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_funct = '0; id_alu_op = '0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_reg_write = 0; exmem_rd = '0; exmem_alu_out = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_write_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [1:0] tbl_op  [8];
    logic [5:0] tbl_fn  [8];
    logic [3:0] tbl_exp [8];

    initial begin
        tbl_op  = '{2'b10,     2'b10,     2'b10,     2'b10,     2'b10,     2'b10,     2'b01,     2'b11};
        tbl_fn  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000, 6'b100100, 6'b100010};
        tbl_exp = '{4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1100,   4'b1111,   4'b0110,   4'b0001};

        stall = 0; flush = 0; reset = 0;
        clear_inputs();
        id_reg_write = 1; id_read_data1 = 32'h99;
        #1 reset = 1;
        #2;
        check("rst_alu_control", alu_control, 4'b0010);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_reg_write", ex_reg_write, 0);
        check("rst_write_reg", ex_write_reg, 0);

        // R-type add, no hazards
        @(negedge clk);
        reset = 0;
        clear_inputs();
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd4;
        id_read_data1 = 32'd5; id_read_data2 = 32'd7;
        id_alu_op = 2'b10; id_funct = 6'b100000; id_reg_dst = 1; id_reg_write = 1;
        step();
        check("add_alu_control", alu_control, 4'b0010);
        check("add_alu_a", alu_a, 32'd5);
        check("add_alu_b", alu_b, 32'd7);
        check("add_write_reg", ex_write_reg, 5'd4);
        check("add_reg_write", ex_reg_write, 1);
        check("add_ex_rs", ex_rs, 5'd1);
        check("add_ex_rt", ex_rt, 5'd2);

        // Double hazard on rs: EX/MEM wins, then MEM/WB, then register value
        clear_inputs();
        id_rs = 5'd3; id_rt = 5'd6; id_rd = 5'd8;
        id_read_data1 = 32'hAA; id_read_data2 = 32'hBB;
        id_alu_op = 2'b10; id_funct = 6'b100000; id_reg_dst = 1; id_reg_write = 1;
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_alu_out = 32'h10;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_write_data = 32'h20;
        step();
        check("fwd_exmem_prio", alu_a, 32'h10);
        check("fwd_b_none", alu_b, 32'hBB);
        exmem_reg_write = 0;
        #1 check("fwd_memwb_a", alu_a, 32'h20);
        memwb_reg_write = 0;
        #1 check("fwd_none_a", alu_a, 32'hAA);
        memwb_reg_write = 1; memwb_rd = 5'd6;
        #1 check("fwd_memwb_b", alu_b, 32'h20);
        check("fwd_memwb_store", ex_store_data, 32'h20);
        exmem_reg_write = 1; exmem_rd = 5'd6;
        #1 check("fwd_exmem_b_prio", ex_store_data, 32'h10);

        // lw with negative offset
        @(negedge clk);
        clear_inputs();
        id_rs = 5'd5; id_rt = 5'd9; id_rd = 5'd0;
        id_read_data1 = 32'h1000; id_read_data2 = 32'h33; id_imm_ext = 32'hFFFF_FFFC;
        id_alu_op = 2'b00; id_funct = 6'b101010; id_alu_src = 1;
        id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
        step();
        check("lw_alu_b", alu_b, 32'hFFFF_FFFC);
        check("lw_alu_a", alu_a, 32'h1000);
        check("lw_alu_control", alu_control, 4'b0010);
        check("lw_mem_read", ex_mem_read, 1);
        check("lw_mem_to_reg", ex_mem_to_reg, 1);
        check("lw_write_reg", ex_write_reg, 5'd9);
        check("lw_store_data", ex_store_data, 32'h33);

        // ALU control decode table
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            id_alu_op = tbl_op[i]; id_funct = tbl_fn[i];
            step();
            check($sformatf("aluctl_%0d", i), alu_control, tbl_exp[i]);
        end

        // Register 0 is never forwarded
        clear_inputs();
        id_read_data1 = 32'h55; id_read_data2 = 32'h66;
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_alu_out = 32'hDEAD;
        memwb_reg_write = 1; memwb_rd = 5'd0; memwb_write_data = 32'hBEEF;
        step();
        check("r0_alu_a", alu_a, 32'h55);
        check("r0_alu_b", alu_b, 32'h66);
        check("r0_store", ex_store_data, 32'h66);

        // Stall holds for two cycles while id_* changes
        clear_inputs();
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd7; id_read_data1 = 32'h111;
        id_alu_op = 2'b01; id_reg_dst = 1; id_reg_write = 1; id_mem_write = 1;
        step();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            id_rs = 5'd10 + 5'(i); id_rd = 5'd20 + 5'(i); id_read_data1 = 32'h900 + i;
            id_alu_op = 2'b11; id_reg_write = 0; id_mem_write = 0;
            step();
            check($sformatf("stall%0d_alu_a", i), alu_a, 32'h111);
            check($sformatf("stall%0d_write_reg", i), ex_write_reg, 5'd7);
            check($sformatf("stall%0d_reg_write", i), ex_reg_write, 1);
            check($sformatf("stall%0d_alu_control", i), alu_control, 4'b0110);
            check($sformatf("stall%0d_ex_rs", i), ex_rs, 5'd1);
        end
        flush = 1;
        id_reg_write = 1; id_mem_write = 1;
        step();
        check("flush_reg_write", ex_reg_write, 0);
        check("flush_mem_write", ex_mem_write, 0);
        check("flush_alu_a", alu_a, 0);
        check("flush_write_reg", ex_write_reg, 0);
        check("flush_alu_control", alu_control, 4'b0010);
        flush = 0; stall = 0;

        // Asynchronous reset between edges while stalled
        clear_inputs();
        id_rs = 5'd4; id_rt = 5'd5; id_read_data1 = 32'h77; id_alu_op = 2'b11;
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_mem_to_reg = 1;
        step();
        check("pre_rst_mem_write", ex_mem_write, 1);
        stall = 1;
        step();
        #2 reset = 1;
        #1;
        check("arst_reg_write", ex_reg_write, 0);
        check("arst_mem_read", ex_mem_read, 0);
        check("arst_mem_write", ex_mem_write, 0);
        check("arst_mem_to_reg", ex_mem_to_reg, 0);
        check("arst_alu_control", alu_control, 4'b0010);
        check("arst_alu_a", alu_a, 0);
        @(negedge clk);
        reset = 0; stall = 0;
        clear_inputs();
        id_rs = 5'd12; id_read_data1 = 32'h1234; id_reg_write = 1;
        step();
        check("post_rst_alu_a", alu_a, 32'h1234);
        check("post_rst_reg_write", ex_reg_write, 1);
        check("post_rst_ex_rs", ex_rs, 5'd12);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have: stall  in  1  hold ID/EX contents; flush  in  1  load bubble into ID/EX.
REQ-003 SHALL have: id_read_data1, id_read_data2, id_imm_ext  in  32 each  ID operands and sign-extended immediate.
REQ-004 SHALL have: id_rs, id_rt, id_rd  in  5 each  register specifiers; id_funct  in  6  R-type function field.
REQ-005 SHALL have: id_alu_op  in  2; id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each.
REQ-006 SHALL have forwarding sources: exmem_reg_write  in  1; exmem_rd  in  5; exmem_alu_out  in  32; memwb_reg_write  in  1; memwb_rd  in  5; memwb_write_data  in  32.
REQ-007 SHALL have: alu_control  out  4; alu_a, alu_b  out  32  ALU operands (rs, rt ports of the ALU).
REQ-008 SHALL have: ex_store_data  out  32; ex_write_reg  out  5; ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each.
REQ-009 SHALL have: ex_rs, ex_rt  out  5 each  registered specifiers for hazard detection.

Function
REQ-010 SHALL capture all id_* inputs into the ID/EX register on each rising clk when stall=0 and flush=0; outputs reflect captured values in the following cycle (1-cycle latency).
REQ-011 SHALL, on flush=1, load a bubble: all control bits 0, specifiers 0, data 0; flush overrides stall.
REQ-012 SHALL, on stall=1 and flush=0, hold every ID/EX field unchanged.
REQ-013 SHALL decode alu_control from registered alu_op/funct: 00->0010 ADD; 01->0110 SUB; 11->0001 OR; 10->funct decode.
REQ-014 SHALL map funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100; any other funct->1111 (ALU yields 0).
REQ-015 SHALL select forward_a: EX/MEM when exmem_reg_write=1, exmem_rd!=0, exmem_rd==ex_rs; else MEM/WB when memwb_reg_write=1, memwb_rd!=0, memwb_rd==ex_rs; else registered read_data1.
REQ-016 SHALL select forward_b by the same rule against ex_rt, giving ex_store_data; EX/MEM has priority when both match.
REQ-017 SHALL drive alu_a = forward_a; alu_b = registered imm_ext when alu_src=1, else forward_b.
REQ-018 SHALL drive ex_write_reg = registered rd when reg_dst=1, else registered rt.
REQ-019 SHALL compute forwarding, alu_control and operand muxing combinationally from the register and live forwarding inputs (no extra cycle).
REQ-020 SHALL never forward for register 0, even when a source claims a write to it.

Reset
REQ-021 SHALL, while reset=1, asynchronously clear every ID/EX field to 0, giving alu_control=0010 (alu_op 00), alu_a=alu_b=0 absent forwarding, all ex_* control outputs 0.
REQ-022 SHALL resume capture on the first rising clk after reset deasserts; reset mid-stall discards held contents.

Structure
REQ-023 SHALL place ALU control codes (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, NONE 1111), alu_op codes and funct constants in shared package pipe_pkg.
REQ-024 SHALL implement the alu_op/funct decode as sub-module alu_control_decode; forwarding and the pipeline register stay in ex_operand_stage.

Verification
REQ-025 Bench SHALL cover: R-type add, rs data 5, rt data 7, alu_op 10, funct 100000, no hazards -> next cycle alu_control=0010, alu_a=5, alu_b=7, ex_write_reg=rd.
REQ-026 Bench SHALL cover: ex_rs=3, exmem_rd=3 (write, out 0x10), memwb_rd=3 (write, data 0x20) -> alu_a=0x10 (EX/MEM priority).
REQ-027 Bench SHALL cover: lw, alu_src=1, imm 0xFFFFFFFC, alu_op 00 -> alu_b=0xFFFFFFFC, alu_control=0010, ex_mem_read=1, ex_write_reg=rt.
REQ-028 Bench SHALL cover: stall=1 two cycles with changing id_* -> outputs unchanged; stall=1 with flush=1 -> bubble, ex_reg_write=0.
REQ-029 Bench SHALL cover: exmem_rd=0 with exmem_reg_write=1, ex_rs=0 -> no forward; funct 000000 with alu_op 10 -> alu_control=1111.
REQ-030 Bench SHALL cover: reset asserted between clock edges mid-operation -> all ex_* control outputs 0 immediately, before the next edge.
